// File: rtl/ap_stage_sequencer.sv
// ap_ctrl_hs sequencer for two chained loop stages: stage 0 runs, then stage 1,
// with saturating per-stage cycle counters for the status monitors.
module ap_stage_sequencer #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             ap_ready,
   output logic             s0_ap_start,
   input  logic             s0_ap_ready,
   input  logic             s0_ap_done,
   output logic             s1_ap_start,
   input  logic             s1_ap_ready,
   input  logic             s1_ap_done,
   output logic [CNT_W-1:0] s0_cycles,
   output logic [CNT_W-1:0] s1_cycles
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S0   = 2'd1,
      ST_S1   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             s0_start_q, s0_start_d;
   logic             s1_start_q, s1_start_d;
   logic [CNT_W-1:0] s0_cnt_q, s0_cnt_d;
   logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   // Next-state logic; stage handshakes are only honoured in their own state.
   always_comb begin
      state_d    = state_q;
      s0_start_d = s0_start_q;
      s1_start_d = s1_start_q;
      s0_cnt_d   = s0_cnt_q;
      s1_cnt_d   = s1_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               state_d    = ST_S0;
               s0_start_d = 1'b1;
               s0_cnt_d   = CNT_ONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_S0: begin
            if (s0_ap_ready || s0_ap_done) begin
               s0_start_d = 1'b0;
            end else begin
               s0_start_d = s0_start_q;
            end
            if (s0_ap_done) begin
               state_d    = ST_S1;
               s1_start_d = 1'b1;
               s1_cnt_d   = CNT_ONE;
            end else begin
               s0_cnt_d = sat_inc(s0_cnt_q);
            end
         end
         ST_S1: begin
            if (s1_ap_ready || s1_ap_done) begin
               s1_start_d = 1'b0;
            end else begin
               s1_start_d = s1_start_q;
            end
            if (s1_ap_done) begin
               state_d = ST_DONE;
            end else begin
               s1_cnt_d = sat_inc(s1_cnt_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            s0_start_d = 1'b0;
            s1_start_d = 1'b0;
         end
      endcase
   end

   // State, stage-start and counter registers.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= ST_IDLE;
         s0_start_q <= 1'b0;
         s1_start_q <= 1'b0;
         s0_cnt_q   <= '0;
         s1_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         s0_start_q <= s0_start_d;
         s1_start_q <= s1_start_d;
         s0_cnt_q   <= s0_cnt_d;
         s1_cnt_q   <= s1_cnt_d;
      end
   end

   assign ap_done     = (state_q == ST_DONE);
   assign ap_ready    = (state_q == ST_DONE);
   assign ap_idle     = (state_q == ST_IDLE) & ~ap_start;
   assign s0_ap_start = s0_start_q;
   assign s1_ap_start = s1_start_q;
   assign s0_cycles   = s0_cnt_q;
   assign s1_cycles   = s1_cnt_q;

endmodule
